cpu_alu_seq: RTL and testbench
==============================

CPU_ALU_SEQ -- requirements
Module: cpu_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from i_op2[SHW-1:0].
REQ-003 SHALL have port i_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  request strobe; accepted only when o_busy=0.
REQ-006 SHALL have port i_abort  input  1  synchronous flush of any in-flight operation.
REQ-007 SHALL have port i_op  input  5  operation code per REQ-010.
REQ-008 SHALL have ports i_op1, i_op2  input  WIDTH  operands, sampled on acceptance only.
REQ-009 SHALL have ports o_busy (1), o_valid (1), o_result (WIDTH), o_compare_result (1)  output.

Function
REQ-010 SHALL decode i_op as follows:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
- 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE, 13 GEU.
- 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- All other codes: o_result=0, o_compare_result=0, 1-cycle latency.
REQ-011 SHALL implement a 3-state FSM: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, MUL*/DIV*/REM*) -> BUSY; BUSY -> (iteration count = WIDTH) -> DONE; DONE -> IDLE unconditionally.
REQ-012 SHALL assert o_busy in BUSY and DONE, and deassert it in IDLE; an i_valid seen while o_busy=1 is ignored without side effect.
REQ-013 SHALL pulse o_valid for exactly one cycle, in DONE, with o_result/o_compare_result valid in that cycle and held until the next acceptance.
REQ-014 SHALL produce a single-cycle op's o_valid 2 cycles after acceptance (accept edge, then DONE edge); arithmetic is mod 2^WIDTH, shifts use i_op2[SHW-1:0], SRA sign-fills.
REQ-015 SHALL drive compare ops as o_compare_result=cmp and o_result={WIDTH-1 zeros, cmp}; all other ops drive o_compare_result=0.
REQ-016 SHALL compute MUL* by iterative shift-add on operand magnitudes into a 2*WIDTH accumulator, one bit per cycle, WIDTH cycles in BUSY, with final negation per the operands' signedness; MUL returns the low half, MULH/MULHSU/MULHU the high half.
REQ-017 SHALL compute DIV*/REM* by restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles, then sign fix-up: quotient sign = sign1^sign2, remainder sign = dividend sign.
REQ-018 SHALL handle divisor = 0 in 1 cycle (skip BUSY): DIV/DIVU return all-ones, REM/REMU return i_op1.
REQ-019 SHALL handle signed overflow (i_op1 = most-negative, i_op2 = -1, DIV/REM) in 1 cycle: DIV returns i_op1, REM returns 0.
REQ-020 SHALL, on i_abort=1, go to IDLE on the next edge with no o_valid pulse and outputs held; i_abort and i_valid asserted in the same cycle drop the request.
REQ-021 SHALL accept a new i_valid in the first IDLE cycle after DONE (back-to-back throughput: 1 result per 2 cycles for single-cycle ops).

Reset
REQ-022 SHALL, on i_reset_n=0 (asynchronous, including mid-operation), force state IDLE, o_busy=0, o_valid=0, o_result=0, o_compare_result=0, accumulators/counters 0.
REQ-023 SHALL accept no request while i_reset_n=0; the first acceptance is possible on the first edge after deassertion.

Configuration
REQ-024 SHALL, with macro CPU_ALU_SEQ_MULDIV_EN defined, implement REQ-016..REQ-019.
REQ-025 SHALL, without CPU_ALU_SEQ_MULDIV_EN, treat codes 16..23 as undefined codes (result 0, 1-cycle), never enter BUSY, and synthesise no multiply/divide datapath.

Verification
REQ-026 SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1 -> o_valid 2 cycles later, o_result=0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-027 SHALL cover: SLT -1 vs 1 -> compare 1, o_result=1; SLTU same operands -> compare 0, o_result=0.
REQ-028 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000 after 34 cycles; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIV -7/2 -> -3, REM -7/2 -> -1; DIVU 5/0 -> 0xFFFFFFFF in 2 cycles; DIV 0x80000000/-1 -> 0x80000000.
REQ-030 SHALL cover: i_abort at BUSY cycle 10 of DIVU -> no o_valid, o_busy=0 next cycle; i_reset_n low mid-MUL -> all outputs 0 immediately; i_valid while busy ignored.

Source files
------------

// File: rtl/cpu_alu_seq.sv
// rtl/cpu_alu_seq.sv - sequential ALU with optional iterative mul/div (CPU_ALU_SEQ_MULDIV_EN)
module cpu_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic             i_abort,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_compare_result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cmp;
  logic             is_cmp;
  logic             start_busy;
  logic [WIDTH-1:0] start_res;
  logic             md_last;
  logic [WIDTH-1:0] md_res;

  assign accept  = (state == S_IDLE) && i_valid && !i_abort;
  assign o_busy  = (state != S_IDLE);
  assign o_valid = (state == S_DONE);

  // Single-cycle operations, evaluated on the live inputs at acceptance
  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    is_cmp  = 1'b0;
    case (i_op)
      5'd0:  alu_res = i_op1 + i_op2;
      5'd1:  alu_res = i_op1 - i_op2;
      5'd2:  alu_res = i_op1 & i_op2;
      5'd3:  alu_res = i_op1 | i_op2;
      5'd4:  alu_res = i_op1 ^ i_op2;
      5'd5:  alu_res = i_op1 << i_op2[SHW-1:0];
      5'd6:  alu_res = i_op1 >> i_op2[SHW-1:0];
      5'd7:  alu_res = $signed(i_op1) >>> i_op2[SHW-1:0];
      5'd8:  begin is_cmp = 1'b1; alu_cmp = ($signed(i_op1) < $signed(i_op2));  end
      5'd9:  begin is_cmp = 1'b1; alu_cmp = (i_op1 < i_op2);                    end
      5'd10: begin is_cmp = 1'b1; alu_cmp = (i_op1 == i_op2);                   end
      5'd11: begin is_cmp = 1'b1; alu_cmp = (i_op1 != i_op2);                   end
      5'd12: begin is_cmp = 1'b1; alu_cmp = ($signed(i_op1) >= $signed(i_op2)); end
      5'd13: begin is_cmp = 1'b1; alu_cmp = (i_op1 >= i_op2);                   end
      default: alu_res = '0;
    endcase
    if (is_cmp) begin
      alu_res = {{(WIDTH-1){1'b0}}, alu_cmp};
    end
  end

`ifdef CPU_ALU_SEQ_MULDIV_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   dsr;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [CW-1:0]      cnt;
  logic [2:0]         md_op;
  logic               neg_q;
  logic               neg_r;
  logic               is_md;
  logic               is_div;
  logic               s1;
  logic               s2;
  logic               fast;

  // Operand signs/magnitudes and the divide special cases that bypass BUSY
  always_comb begin
    is_md  = (i_op[4:3] == 2'b10);
    is_div = i_op[2];
    if (is_div) begin
      s1 = i_op1[WIDTH-1] & ~i_op[0];
      s2 = i_op2[WIDTH-1] & ~i_op[0];
    end else begin
      s1 = i_op1[WIDTH-1] & ~(i_op[1] & i_op[0]);
      s2 = i_op2[WIDTH-1] & ~i_op[1];
    end
    mag1     = s1 ? -i_op1 : i_op1;
    mag2     = s2 ? -i_op2 : i_op2;
    fast     = 1'b0;
    fast_res = '0;
    if (is_md && is_div) begin
      if (i_op2 == '0) begin
        fast     = 1'b1;
        fast_res = i_op[1] ? i_op1 : '1;
      end else if (!i_op[0] && (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op2 == '1)) begin
        fast     = 1'b1;
        fast_res = i_op[1] ? '0 : i_op1;
      end
    end
    start_busy = is_md && !fast;
    start_res  = fast ? fast_res : alu_res;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step, plus sign fix-up
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : {(WIDTH+1){1'b0}});
    sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    if (!md_op[2]) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else if (sh >= {1'b0, dsr}) begin
      acc_nxt = {sh[WIDTH-1:0] - dsr, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    prod  = neg_q ? -acc_nxt : acc_nxt;
    q_fin = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    r_fin = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    if (!md_op[2]) begin
      md_res = (md_op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else begin
      md_res = md_op[1] ? r_fin : q_fin;
    end
    md_last = (cnt == CW'(WIDTH - 1));
  end

  // Iterative datapath registers: loaded on acceptance, stepped once per BUSY cycle
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      md_op <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && start_busy) begin
      acc   <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
      dsr   <= is_div ? mag2 : mag1;
      cnt   <= '0;
      md_op <= i_op[2:0];
      neg_q <= s1 ^ s2;
      neg_r <= s1;
    end else if ((state == S_BUSY) && !i_abort) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign start_busy = 1'b0;
  assign start_res  = alu_res;
  assign md_last    = 1'b1;
  assign md_res     = '0;
`endif

  // Control FSM; results load only when DONE is entered, otherwise held
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= S_IDLE;
      o_result         <= '0;
      o_compare_result <= 1'b0;
    end else if (i_abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (start_busy) begin
              state <= S_BUSY;
            end else begin
              state            <= S_DONE;
              o_result         <= start_res;
              o_compare_result <= alu_cmp;
            end
          end
        end
        S_BUSY: begin
          if (md_last) begin
            state            <= S_DONE;
            o_result         <= md_res;
            o_compare_result <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb/tb_cpu_alu_seq.sv - self-checking bench for cpu_alu_seq
module tb_cpu_alu_seq;

  localparam int W = 32;
`ifdef CPU_ALU_SEQ_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic         i_valid;
  logic         i_abort;
  logic [4:0]   i_op;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic         o_busy;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic         o_compare_result;

  int  vectors;
  int  miscompares;
  time last_done;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_cmp;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];

  cpu_alu_seq #(.WIDTH(W)) dut (
    .i_clock          (clk),
    .i_reset_n        (i_reset_n),
    .i_valid          (i_valid),
    .i_abort          (i_abort),
    .i_op             (i_op),
    .i_op1            (i_op1),
    .i_op2            (i_op2),
    .o_busy           (o_busy),
    .o_valid          (o_valid),
    .o_result         (o_result),
    .o_compare_result (o_compare_result)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on whole values, latency from the op class
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output int lat);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [2*W-1:0]      p;
    sa  = a;
    sb  = b;
    r   = '0;
    c   = 1'b0;
    lat = 2;
    p   = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = sa >>> b[4:0];
      5'd8:  c = (sa < sb);
      5'd9:  c = (a < b);
      5'd10: c = (a == b);
      5'd11: c = (a != b);
      5'd12: c = (sa >= sb);
      5'd13: c = (a >= b);
      default: begin
        if (MD_ON && op >= 16 && op <= 19) begin
          lat = W + 2;
          case (op)
            5'd16: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
            5'd17: begin p = {{32{a[W-1]}}, a} * {{32{b[W-1]}}, b}; r = p[2*W-1:W]; end
            5'd18: begin p = {{32{a[W-1]}}, a} * {32'b0, b}; r = p[2*W-1:W]; end
            default: begin p = {32'b0, a} * {32'b0, b}; r = p[2*W-1:W]; end
          endcase
        end else if (MD_ON && op >= 20 && op <= 23) begin
          if (b == 0) begin
            r = (op == 20 || op == 21) ? '1 : a;
          end else if ((op == 20 || op == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = (op == 20) ? a : '0;
          end else begin
            lat = W + 2;
            case (op)
              5'd20:   r = sa / sb;
              5'd21:   r = a / b;
              5'd22:   r = sa % sb;
              default: r = a % b;
            endcase
          end
        end
      end
    endcase
    if (op >= 8 && op <= 13) r = {31'b0, c};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, then report result, compare flag and edges until o_valid is sampled
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_valid, output logic [W-1:0] res, output logic cmp, output int lat);
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_busy) check("idle_wait_timeout", 64'(o_busy), 64'd0);
    i_valid = 1'b1;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
    @(posedge clk); #1;
    i_valid = hold_valid;
    i_op    = hold_valid ? 5'd0 : 5'($urandom);
    i_op1   = $urandom;
    i_op2   = $urandom;
    n = 1;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat       = o_valid ? n + 1 : -1;
    res       = o_result;
    cmp       = o_compare_result;
    last_done = $time;
    if (hold_valid) begin
      @(posedge clk); #1;
      check("valid_while_busy_ignored", 64'(o_busy), 64'd0);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] res;
    logic         cmp;
    logic [W-1:0] exp_r;
    logic         exp_c;
    int           lat;
    int           exp_l;
    int           seen;
    time          t0;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           hold;

    vectors     = 0;
    miscompares = 0;
    i_reset_n   = 1'b0;
    i_valid     = 1'b0;
    i_abort     = 1'b0;
    i_op        = '0;
    i_op1       = '0;
    i_op2       = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_result", 64'(o_result), 64'd0);
    check("reset_cmp", 64'(o_compare_result), 64'd0);
    i_reset_n = 1'b1;

    vecs.push_back('{5'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 2});
    vecs.push_back('{5'd8,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b1, 2});
    vecs.push_back('{5'd9,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 2});
    vecs.push_back('{5'd5,  32'd1,         32'd35,        32'h0000_0008, 1'b0, 2});
    vecs.push_back('{5'd6,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 2});
    vecs.push_back('{5'd10, 32'd5,         32'd5,         32'h0000_0001, 1'b1, 2});
    vecs.push_back('{5'd11, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd13, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b1, 2});
    vecs.push_back('{5'd14, 32'd9,         32'd9,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{5'd17, 32'h8000_0000, 32'h8000_0000, MD_ON ? 32'h4000_0000 : 32'h0, 1'b0, MD_ON ? 34 : 2});
    vecs.push_back('{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0, MD_ON ? 34 : 2});
    vecs.push_back('{5'd16, 32'd7,         32'hFFFF_FFFD, MD_ON ? 32'hFFFF_FFEB : 32'h0, 1'b0, MD_ON ? 34 : 2});
    vecs.push_back('{5'd20, 32'hFFFF_FFF9, 32'd2,         MD_ON ? 32'hFFFF_FFFD : 32'h0, 1'b0, MD_ON ? 34 : 2});
    vecs.push_back('{5'd22, 32'hFFFF_FFF9, 32'd2,         MD_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0, MD_ON ? 34 : 2});
    vecs.push_back('{5'd21, 32'd5,         32'd0,         MD_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0, 2});
    vecs.push_back('{5'd23, 32'd5,         32'd0,         MD_ON ? 32'h0000_0005 : 32'h0, 1'b0, 2});
    vecs.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, MD_ON ? 32'h8000_0000 : 32'h0, 1'b0, 2});
    vecs.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2});

    foreach (vecs[k]) begin
      run_op(vecs[k].op, vecs[k].a, vecs[k].b, 1'b0, res, cmp, lat);
      check($sformatf("vec%0d_op%0d_result", k, vecs[k].op), 64'(res), 64'(vecs[k].exp_res));
      check($sformatf("vec%0d_op%0d_cmp", k, vecs[k].op), 64'(cmp), 64'(vecs[k].exp_cmp));
      check($sformatf("vec%0d_op%0d_latency", k, vecs[k].op), 64'(lat), 64'(vecs[k].exp_lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_single_pulse", k), {62'b0, o_valid, o_busy}, 64'd0);
    end

    // Back-to-back single-cycle ops: one result every two cycles
    run_op(5'd0, 32'd1, 32'd2, 1'b0, res, cmp, lat);
    t0 = last_done;
    run_op(5'd0, 32'd3, 32'd4, 1'b0, res, cmp, lat);
    check("back_to_back_spacing", 64'(last_done - t0), 64'd20);
    check("back_to_back_result", 64'(res), 64'd7);

    // Request with abort in the same cycle is dropped
    i_valid = 1'b1; i_abort = 1'b1; i_op = 5'd0; i_op1 = 32'd40; i_op2 = 32'd2;
    @(posedge clk); #1;
    i_valid = 1'b0; i_abort = 1'b0;
    check("abort_with_valid_busy", 64'(o_busy), 64'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("abort_with_valid_no_result", 64'(seen), 64'd0);
    check("abort_with_valid_held", 64'(o_result), 64'd7);

`ifdef CPU_ALU_SEQ_MULDIV_EN
    // Abort in BUSY cycle 10 of DIVU
    i_valid = 1'b1; i_op = 5'd21; i_op1 = 32'd1000; i_op2 = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("divu_busy_at_cycle10", 64'(o_busy), 64'd1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check("abort_busy_cleared", 64'(o_busy), 64'd0);
    check("abort_result_held", 64'(o_result), 64'd7);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("abort_no_valid_pulse", 64'(seen), 64'd0);

    // MUL with ADD requests held during BUSY/DONE: ignored
    run_op(5'd16, 32'd123, 32'd456, 1'b1, res, cmp, lat);
    check("mul_hold_result", 64'(res), 64'd56088);
    check("mul_hold_latency", 64'(lat), 64'd34);
`endif

    // Asynchronous reset mid-operation
    i_valid = 1'b1; i_op = 5'd0; i_op1 = 32'd5; i_op2 = 32'd6;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("pre_reset_result", 64'(o_result), 64'd11);
`ifdef CPU_ALU_SEQ_MULDIV_EN
    @(posedge clk); #1;
    i_valid = 1'b1; i_op = 5'd16; i_op1 = 32'd3; i_op2 = 32'd5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`endif
    i_reset_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(o_busy), 64'd0);
    check("async_reset_valid", 64'(o_valid), 64'd0);
    check("async_reset_result", 64'(o_result), 64'd0);
    check("async_reset_cmp", 64'(o_compare_result), 64'd0);
    i_valid = 1'b1; i_op = 5'd0; i_op1 = 32'd2; i_op2 = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("no_accept_in_reset", 64'(o_busy), 64'd0);
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("first_edge_accept_valid", 64'(o_valid), 64'd1);
    check("first_edge_accept_result", 64'(o_result), 64'd5);
    @(posedge clk); #1;

    // Randomised ops against the reference model
    for (int i = 0; i < 250; i++) begin
      op   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      a    = pick_operand();
      b    = pick_operand();
      hold = ($urandom_range(0, 3) == 0);
      model(op, a, b, exp_r, exp_c, exp_l);
      run_op(op, a, b, hold, res, cmp, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_result", i, op, a, b), 64'(res), 64'(exp_r));
      check($sformatf("rand%0d_op%0d_cmp", i, op), 64'(cmp), 64'(exp_c));
      check($sformatf("rand%0d_op%0d_latency", i, op), 64'(lat), 64'(exp_l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
